obi_to_apb_bridge: RTL and testbench
====================================

# obi_to_apb_bridge

Bridge from an OBI subordinate port (X-HEEP OBI signal set) to an APB4 manager port, the reverse of our APB-to-OBI path. It lets OBI masters on the X-HEEP bus reach APB peripherals. It supports one outstanding transaction, converting each OBI request into an APB SETUP/ACCESS sequence. The APB completion is returned as a single-cycle OBI `rvalid`.

## Interface
- `AddrWidth`, 32, OBI/APB address width.
- `DataWidth`, 32, data width; must be a multiple of 8.
- `TimeoutCycles`, 1024, ACCESS cycles without `pready` before abort (used only with the timeout macro); must be ≥1.

- `clk_i`  in  1  clock; single clock domain.
- `rst_ni`  in  1  reset; synchronous, active-low.
- `obi_req_i`  in  1  OBI request.
- `obi_gnt_o`  out  1  OBI grant.
- `obi_addr_i`  in  AddrWidth  OBI address.
- `obi_we_i`  in  1  1 = write.
- `obi_be_i`  in  DataWidth/8  byte enables.
- `obi_wdata_i`  in  DataWidth  write data.
- `obi_rvalid_o`  out  1  response valid, one cycle.
- `obi_rdata_o`  out  DataWidth  read data.
- `obi_err_o`  out  1  response error, valid with `obi_rvalid_o`.
- `psel_o`, `penable_o`, `pwrite_o`  out  1 each  APB control.
- `paddr_o`  out  AddrWidth  APB address.
- `pwdata_o`  out  DataWidth  APB write data.
- `pstrb_o`  out  DataWidth/8  APB strobes.
- `pprot_o`  out  3  tied to 3'b000.
- `pready_i`, `pslverr_i`  in  1 each  APB completion and error.
- `prdata_i`  in  DataWidth  APB read data.

## Operation
- The FSM has four states: IDLE, SETUP, ACCESS, RESP.
- **IDLE:**
  - `obi_gnt_o = obi_req_i & rst_ni` (combinational).
  - On `req & gnt`, register addr, we, be and wdata, then go to SETUP.
- **SETUP:**
  - `psel=1`, `penable=0`, with address, write and data driven from the registers.
  - Always moves to ACCESS after one cycle.
- **ACCESS:**
  - `psel=1`, `penable=1`.
  - If `pready_i`, capture the response and go to RESP:
    - `obi_rdata` = `prdata_i` for a read, 0 for a write.
    - `obi_err` = `pslverr_i`.
  - Otherwise stay in ACCESS with all APB outputs held stable.
- **RESP:**
  - `obi_rvalid_o=1` for exactly one cycle, with the registered rdata/err.
  - `psel=0`; next state is IDLE.
- `pstrb_o` = registered `be` for writes and all zeros for reads (APB4 rule).
- `obi_gnt_o` is 0 in SETUP, ACCESS and RESP. A request arriving then is held by the master until the bridge returns to IDLE.
- Outside SETUP/ACCESS: `psel_o=0`, `penable_o=0`. `paddr`, `pwrite`, `pwdata` and `pstrb` keep their last registered values.
- Reset, including mid-transaction:
  - At the clock edge where `rst_ni=0`, the state goes to IDLE and all registers clear.
  - The in-flight transaction is dropped with no `rvalid`.
  - APB outputs drop to 0 the following cycle.
- Reset values: `psel`, `penable`, `pwrite`, `paddr`, `pwdata`, `pstrb`, `obi_rvalid`, `obi_rdata`, `obi_err` are all 0. `obi_gnt_o` is 0 while `rst_ni=0`.

## Timing
- Grant is in cycle T; SETUP is T+1; ACCESS is T+2 onwards.
- If `pready` is seen in cycle T+2+k, `rvalid` is asserted in T+3+k.
- Minimum latency is 3 cycles from grant to `rvalid`.
- Minimum issue interval is 4 cycles per transaction; the next grant is possible at T+4 (IDLE).
- `pready_i` and `pslverr_i` are sampled only in ACCESS and ignored in all other states.
- `prdata_i` is sampled only when `pready_i` is high in ACCESS.

## Configuration
- Macro: `OBI_TO_APB_TIMEOUT_EN`.
- **Defined:**
  - A counter of width `$clog2(TimeoutCycles+1)` clears on entry to ACCESS and increments each ACCESS cycle without `pready_i`.
  - When the count reaches `TimeoutCycles`, the bridge leaves ACCESS for RESP with `obi_err=1` and `obi_rdata=0`. `psel`/`penable` deassert in that RESP cycle.
  - If `pready_i` is high in the same cycle as the count reaches the limit, `pready_i` wins and the normal response is returned.
- **Undefined:** no counter is built, and ACCESS waits for `pready_i` indefinitely.

## Test plan
- **Read:** req with addr=0x1000, we=0; APB holds `pready=1` on the first ACCESS cycle with `prdata=0xDEADBEEF`. Expect gnt at T, `psel` in T+1 and T+2, `penable` only in T+2, `pstrb=0`, and `rvalid` in T+3 with rdata=0xDEADBEEF, err=0.
- **Write:** addr=0x2004, wdata=0x12345678, be=4'b0110; `pready` delayed 3 cycles, then `pslverr=1`. Expect `pwrite=1`, `pstrb=0110`, and APB outputs stable through wait states. `rvalid` arrives 1 cycle after `pready`, with err=1 and rdata=0.
- **Back-to-back:** master holds `req=1` for two reads. Expect `gnt` only in IDLE; the second grant comes exactly 4 cycles after the first when `pready` is immediate.
- **Reset mid-ACCESS:** drive `rst_ni=0` for one edge while in ACCESS. Expect `psel`/`penable` 0 the next cycle, no `rvalid`, and a new request granted after release.
- **Timeout (macro on, TimeoutCycles=4):** `pready` is held low. Expect `rvalid` with err=1 and rdata=0 after 4 ACCESS cycles, followed by IDLE. With the macro off, the same stimulus leaves the bridge in ACCESS for 100 cycles.
- **Timeout tie:** `pready=1` in the cycle the counter hits the limit, with `prdata=0xA5A5A5A5`. Expect a normal response carrying rdata=0xA5A5A5A5 and err=0.

Source files
------------

// File: rtl/obi_to_apb_bridge.sv
// obi_to_apb_bridge
//
// Bridges an OBI subordinate port to an APB4 manager port. Only one
// transaction can be outstanding at a time. Each granted OBI request becomes
// an APB SETUP/ACCESS sequence. The APB completion is returned to the OBI
// side as a single-cycle rvalid pulse.
//
// Optional feature: define OBI_TO_APB_TIMEOUT_EN to abort an ACCESS phase
// after TimeoutCycles cycles without pready_i. An aborted transaction
// returns err=1 and rdata=0.
//
// Ports:
//   clk_i, rst_ni        clock; synchronous active-low reset
//   obi_req_i/gnt_o      OBI request handshake (grant only in IDLE)
//   obi_addr_i/we_i/be_i/wdata_i  OBI request payload
//   obi_rvalid_o/rdata_o/err_o    OBI response (one cycle)
//   psel_o/penable_o/pwrite_o/paddr_o/pwdata_o/pstrb_o/pprot_o  APB request
//   pready_i/pslverr_i/prdata_i   APB completion
module obi_to_apb_bridge #(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  // OBI subordinate
  input  logic                   obi_req_i,
  output logic                   obi_gnt_o,
  input  logic [AddrWidth-1:0]   obi_addr_i,
  input  logic                   obi_we_i,
  input  logic [DataWidth/8-1:0] obi_be_i,
  input  logic [DataWidth-1:0]   obi_wdata_i,
  output logic                   obi_rvalid_o,
  output logic [DataWidth-1:0]   obi_rdata_o,
  output logic                   obi_err_o,
  // APB4 manager
  output logic                   psel_o,
  output logic                   penable_o,
  output logic                   pwrite_o,
  output logic [AddrWidth-1:0]   paddr_o,
  output logic [DataWidth-1:0]   pwdata_o,
  output logic [DataWidth/8-1:0] pstrb_o,
  output logic [2:0]             pprot_o,
  input  logic                   pready_i,
  input  logic                   pslverr_i,
  input  logic [DataWidth-1:0]   prdata_i
);

  localparam int unsigned BeWidth = DataWidth / 8;

  // Elaboration-time parameter sanity checks.
  if (DataWidth % 8 != 0) begin : g_bad_data_width
    $error("DataWidth must be a multiple of 8");
  end
  if (TimeoutCycles < 1) begin : g_bad_timeout
    $error("TimeoutCycles must be at least 1");
  end

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   paddr_q, paddr_d;
  logic                   pwrite_q, pwrite_d;
  logic [DataWidth-1:0]   pwdata_q, pwdata_d;
  logic [BeWidth-1:0]     be_q, be_d;
  logic [DataWidth-1:0]   rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic                   gnt;

`ifdef OBI_TO_APB_TIMEOUT_EN
  localparam int unsigned CntWidth = $clog2(TimeoutCycles + 1);
  logic [CntWidth-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d      = state_q;
    paddr_d      = paddr_q;
    pwrite_d     = pwrite_q;
    pwdata_d     = pwdata_q;
    be_d         = be_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    gnt          = 1'b0;
    psel_o       = 1'b0;
    penable_o    = 1'b0;
    obi_rvalid_o = 1'b0;
`ifdef OBI_TO_APB_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif

    unique case (state_q)
      StIdle: begin
        gnt = obi_req_i & rst_ni;
        if (gnt) begin
          paddr_d  = obi_addr_i;
          pwrite_d = obi_we_i;
          pwdata_d = obi_wdata_i;
          be_d     = obi_be_i;
          state_d  = StSetup;
        end
      end
      StSetup: begin
        psel_o  = 1'b1;
        state_d = StAccess;
`ifdef OBI_TO_APB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      StAccess: begin
        psel_o    = 1'b1;
        penable_o = 1'b1;
        if (pready_i) begin
          rdata_d = pwrite_q ? '0 : prdata_i;
          err_d   = pslverr_i;
          state_d = StResp;
        end
`ifdef OBI_TO_APB_TIMEOUT_EN
        // This cycle is the TimeoutCycles-th one without pready: abort.
        else if (cnt_q == CntWidth'(TimeoutCycles - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      StResp: begin
        obi_rvalid_o = 1'b1;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      be_q     <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
`ifdef OBI_TO_APB_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      be_q     <= be_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
`ifdef OBI_TO_APB_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign obi_gnt_o   = gnt;
  assign obi_rdata_o = rdata_q;
  assign obi_err_o   = err_q;
  assign paddr_o     = paddr_q;
  assign pwrite_o    = pwrite_q;
  assign pwdata_o    = pwdata_q;
  // APB4 requires all-zero strobes on reads.
  assign pstrb_o     = pwrite_q ? be_q : '0;
  assign pprot_o     = 3'b000;

endmodule

// File: tb/tb_obi_to_apb_bridge.sv
module tb_obi_to_apb_bridge;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          obi_req;
  logic          obi_gnt;
  logic [AW-1:0] obi_addr;
  logic          obi_we;
  logic [3:0]    obi_be;
  logic [DW-1:0] obi_wdata;
  logic          obi_rvalid;
  logic [DW-1:0] obi_rdata;
  logic          obi_err;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [3:0]    pstrb;
  logic [2:0]    pprot;
  logic          pready, pslverr;
  logic [DW-1:0] prdata;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  obi_to_apb_bridge #(
    .AddrWidth    (AW),
    .DataWidth    (DW),
    .TimeoutCycles(TO)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .obi_req_i   (obi_req),
    .obi_gnt_o   (obi_gnt),
    .obi_addr_i  (obi_addr),
    .obi_we_i    (obi_we),
    .obi_be_i    (obi_be),
    .obi_wdata_i (obi_wdata),
    .obi_rvalid_o(obi_rvalid),
    .obi_rdata_o (obi_rdata),
    .obi_err_o   (obi_err),
    .psel_o      (psel),
    .penable_o   (penable),
    .pwrite_o    (pwrite),
    .paddr_o     (paddr),
    .pwdata_o    (pwdata),
    .pstrb_o     (pstrb),
    .pprot_o     (pprot),
    .pready_i    (pready),
    .pslverr_i   (pslverr),
    .prdata_i    (prdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_req();
    obi_addr  = $urandom;
    obi_wdata = $urandom;
    obi_be    = 4'($urandom);
    obi_we    = 1'($urandom);
  endtask

  // Reference transaction: grant in T, SETUP in T+1, ACCESS T+2..T+2+k,
  // rvalid in T+3+k. Returns the grant cycle.
  task automatic run_txn(input logic [31:0] addr, input logic we, input logic [3:0] be,
                         input logic [31:0] wdata, input int k, input logic slverr,
                         input logic [31:0] rd, output int t_gnt);
    logic [3:0]  exp_strb;
    logic [31:0] exp_rdata;
    exp_strb  = we ? be : 4'b0000;
    exp_rdata = we ? 32'h0 : rd;
    obi_req   = 1'b1;
    obi_addr  = addr;
    obi_we    = we;
    obi_be    = be;
    obi_wdata = wdata;
    pready    = 1'b0;
    @(negedge clk);
    check("idle_gnt", obi_gnt, 1'b1);
    check("idle_psel", psel, 1'b0);
    check("idle_rvalid", obi_rvalid, 1'b0);
    t_gnt = cyc;
    next_cycle();
    obi_req = 1'b0;
    scramble_req();
    @(negedge clk);
    check("setup_psel", psel, 1'b1);
    check("setup_penable", penable, 1'b0);
    check("setup_paddr", paddr, addr);
    check("setup_pwrite", pwrite, we);
    check("setup_pwdata", pwdata, wdata);
    check("setup_pstrb", pstrb, exp_strb);
    check("setup_gnt", obi_gnt, 1'b0);
    for (int i = 0; i <= k; i++) begin
      next_cycle();
      pready  = (i == k);
      pslverr = (i == k) ? slverr : 1'($urandom);
      prdata  = (i == k) ? rd : $urandom;
      @(negedge clk);
      check("access_psel", psel, 1'b1);
      check("access_penable", penable, 1'b1);
      check("access_paddr", paddr, addr);
      check("access_pwrite", pwrite, we);
      check("access_pwdata", pwdata, wdata);
      check("access_pstrb", pstrb, exp_strb);
      check("access_rvalid", obi_rvalid, 1'b0);
    end
    next_cycle();
    // pready/pslverr are don't-care outside ACCESS; master re-requests early.
    pready  = 1'($urandom);
    pslverr = 1'($urandom);
    prdata  = $urandom;
    obi_req = 1'b1;
    @(negedge clk);
    check("resp_rvalid", obi_rvalid, 1'b1);
    check("resp_rdata", obi_rdata, exp_rdata);
    check("resp_err", obi_err, slverr);
    check("resp_psel", psel, 1'b0);
    check("resp_penable", penable, 1'b0);
    check("resp_gnt", obi_gnt, 1'b0);
    check("resp_paddr_hold", paddr, addr);
    check("resp_pstrb_hold", pstrb, exp_strb);
    next_cycle();
    obi_req = 1'b0;
    pready  = 1'b0;
    pslverr = 1'b0;
  endtask

  initial begin
    int t1, t2, t_prev, k;
    logic we;
    rst_n     = 1'b0;
    obi_req   = 1'b1;
    obi_addr  = 32'h0;
    obi_we    = 1'b0;
    obi_be    = 4'h0;
    obi_wdata = 32'h0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    prdata    = 32'h0;

    // Reset state
    @(negedge clk);
    check("rst_gnt", obi_gnt, 1'b0);
    check("rst_psel", psel, 1'b0);
    check("rst_penable", penable, 1'b0);
    check("rst_pwrite", pwrite, 1'b0);
    check("rst_paddr", paddr, 32'h0);
    check("rst_pwdata", pwdata, 32'h0);
    check("rst_pstrb", pstrb, 4'h0);
    check("rst_rvalid", obi_rvalid, 1'b0);
    check("rst_rdata", obi_rdata, 32'h0);
    check("rst_err", obi_err, 1'b0);
    check("pprot", pprot, 3'b000);
    next_cycle();
    rst_n   = 1'b1;
    obi_req = 1'b0;
    @(negedge clk);
    check("idle_noreq_gnt", obi_gnt, 1'b0);
    next_cycle();

    // Directed read and write
    run_txn(32'h1000, 1'b0, 4'hF, 32'h0, 0, 1'b0, 32'hDEADBEEF, t1);
    run_txn(32'h2004, 1'b1, 4'b0110, 32'h12345678, 3, 1'b1, 32'hFFFF_FFFF, t1);

    // Back-to-back reads with immediate pready
    run_txn(32'h3000, 1'b0, 4'hF, 32'h0, 0, 1'b0, 32'h1111_2222, t1);
    run_txn(32'h3004, 1'b0, 4'hF, 32'h0, 0, 1'b0, 32'h3333_4444, t2);
    check("b2b_interval", 64'(t2 - t1), 64'd4);

    // Reset in the middle of ACCESS
    obi_req   = 1'b1;
    obi_addr  = 32'h4000;
    obi_we    = 1'b1;
    obi_be    = 4'hF;
    obi_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    check("rstmid_gnt", obi_gnt, 1'b1);
    next_cycle();
    obi_req = 1'b0;
    next_cycle();
    @(negedge clk);
    check("rstmid_penable", penable, 1'b1);
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check("rstmid_psel", psel, 1'b0);
    check("rstmid_penable0", penable, 1'b0);
    check("rstmid_paddr", paddr, 32'h0);
    check("rstmid_pwrite", pwrite, 1'b0);
    check("rstmid_pstrb", pstrb, 4'h0);
    for (int i = 0; i < 3; i++) begin
      check("rstmid_rvalid", obi_rvalid, 1'b0);
      next_cycle();
      @(negedge clk);
    end
    next_cycle();
    run_txn(32'h4008, 1'b0, 4'hF, 32'h0, 1, 1'b0, 32'h5555_6666, t1);

    // Stalled ACCESS (pready held low)
    obi_req  = 1'b1;
    obi_addr = 32'h5000;
    obi_we   = 1'b0;
    obi_be   = 4'hF;
    pready   = 1'b0;
    prdata   = 32'h7777_8888;
    @(negedge clk);
    check("stall_gnt", obi_gnt, 1'b1);
    next_cycle();
    obi_req = 1'b0;
`ifdef OBI_TO_APB_TIMEOUT_EN
    for (int i = 0; i < int'(TO); i++) begin
      next_cycle();
      @(negedge clk);
      check("to_penable", penable, 1'b1);
      check("to_rvalid", obi_rvalid, 1'b0);
    end
    next_cycle();
    @(negedge clk);
    check("to_resp_rvalid", obi_rvalid, 1'b1);
    check("to_resp_err", obi_err, 1'b1);
    check("to_resp_rdata", obi_rdata, 32'h0);
    check("to_resp_psel", psel, 1'b0);
    check("to_resp_penable", penable, 1'b0);
    next_cycle();
    @(negedge clk);
    check("to_idle_rvalid", obi_rvalid, 1'b0);
    check("to_idle_psel", psel, 1'b0);
    next_cycle();
    // pready wins in the cycle the limit is reached
    run_txn(32'h5004, 1'b0, 4'hF, 32'h0, int'(TO) - 1, 1'b0, 32'hA5A5A5A5, t1);
`else
    for (int i = 0; i < 100; i++) begin
      next_cycle();
      @(negedge clk);
      check("stall_psel", psel, 1'b1);
      check("stall_penable", penable, 1'b1);
      check("stall_rvalid", obi_rvalid, 1'b0);
    end
    pready = 1'b1;
    next_cycle();
    pready = 1'b0;
    @(negedge clk);
    check("stall_resp_rvalid", obi_rvalid, 1'b1);
    check("stall_resp_rdata", obi_rdata, 32'h7777_8888);
    check("stall_resp_err", obi_err, 1'b0);
    next_cycle();
`endif

    // Randomized transactions with random idle gaps
    t_prev = -1;
    k      = 0;
    for (int n = 0; n < 30; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        obi_req = 1'b0;
        @(negedge clk);
        check("gap_gnt", obi_gnt, 1'b0);
        check("gap_psel", psel, 1'b0);
        check("gap_rvalid", obi_rvalid, 1'b0);
        next_cycle();
      end
      we = 1'($urandom);
      k  = $urandom_range(0, 3);
      run_txn($urandom, we, 4'($urandom), $urandom, k, 1'($urandom), $urandom, t1);
      t_prev = t1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
